// File: rtl/sha256_compress.sv
// SHA-256 single-block compression engine.
// Accepts a chaining value and one padded 512-bit block, runs one round per
// clock, then adds the working registers back into the saved chaining value.
module sha256_compress (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] H_in,
  input  logic [511:0] M_in,
  input  logic         input_valid,
  output logic [255:0] H_out,
  output logic         output_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  logic [1:0]   state;
  // t runs 0..63 for the rounds; the extra value 64 is the finalize step
  logic [6:0]   t;
  logic [255:0] h_saved;
  logic [31:0]  a, b, c, d, e, f, g, h;
  // w[0] always holds W[t]; w[k] holds W[t+k]
  logic [31:0]  w [0:15];
  logic [31:0]  t1, t2, w_next;

  // Round function and next schedule word for the current window position
  always_comb begin
    t1     = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K[t[5:0]] + w[0];
    t2     = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  // Control FSM, working registers, message window and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      t            <= '0;
      h_saved      <= '0;
      {a, b, c, d} <= '0;
      {e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      H_out        <= '0;
      output_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid) begin
            h_saved <= H_in;
            a <= H_in[255:224];
            b <= H_in[223:192];
            c <= H_in[191:160];
            d <= H_in[159:128];
            e <= H_in[127:96];
            f <= H_in[95:64];
            g <= H_in[63:32];
            h <= H_in[31:0];
            for (int i = 0; i < 16; i++) w[i] <= M_in[511-32*i -: 32];
            t     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (t == 7'd64) begin
            H_out <= {h_saved[255:224] + a, h_saved[223:192] + b,
                      h_saved[191:160] + c, h_saved[159:128] + d,
                      h_saved[127:96]  + e, h_saved[95:64]   + f,
                      h_saved[63:32]   + g, h_saved[31:0]    + h};
            output_valid <= 1'b1;
            state        <= DONE;
          end else begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
            t     <= t + 7'd1;
          end
        end
        DONE: begin
          if (!input_valid) begin
            output_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known FIPS vectors, a two-block
// message, input scrambling, aborts, hold in DONE, and random blocks checked
// against a straightforward software model of the compression function.
module tb_sha256_compress;

  logic         clk;
  logic         rst_n;
  logic [255:0] H_in;
  logic [511:0] M_in;
  logic         input_valid;
  logic [255:0] H_out;
  logic         output_valid;

  int errors = 0;
  int checks = 0;
  int rise_cnt = 0;
  logic prev_valid = 1'b0;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] KTAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_compress dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .H_in         (H_in),
    .M_in         (M_in),
    .input_valid  (input_valid),
    .H_out        (H_out),
    .output_valid (output_valid)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges of output_valid, sampled away from the active edge
  always @(negedge clk) begin
    if (output_valid && !prev_valid) rise_cnt++;
    prev_valid = output_valid;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-word schedule, then 64 rounds on an array
  function automatic logic [255:0] sha_model(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] wm [0:63];
    logic [31:0] v [0:7];
    logic [31:0] x, y;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) wm[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      wm[i] = (rotr(wm[i-2], 17) ^ rotr(wm[i-2], 19) ^ (wm[i-2] >> 10)) + wm[i-7]
            + (rotr(wm[i-15], 7) ^ rotr(wm[i-15], 18) ^ (wm[i-15] >> 3)) + wm[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int r_i = 0; r_i < 64; r_i++) begin
      x = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
        + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KTAB[r_i] + wm[r_i];
      y = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
        + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x;
      v[0] = x + y;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] hv, input logic [511:0] mv);
    H_in        = hv;
    M_in        = mv;
    input_valid = 1'b1;
  endtask

  // One job from IDLE: accept edge, 64 quiet edges, result on the 65th, then release
  task automatic run_job(input string tag, input logic [255:0] hv, input logic [511:0] mv,
                         input logic [255:0] exp, input bit scramble);
    applyStimulus(hv, mv);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        H_in = rand256();
        M_in = rand512();
      end
    end
    checkOutput({tag, "_not_early"}, {255'b0, output_valid}, 256'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, {255'b0, output_valid}, 256'd1);
    checkOutput({tag, "_hash"}, H_out, exp);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_clear"}, {255'b0, output_valid}, 256'd0);
    checkOutput({tag, "_hash_kept"}, H_out, exp);
  endtask

  logic [511:0] abc_blk, empty_blk, two_b1, two_b2, mv;
  logic [255:0] hv, r1_exp, last_exp;
  int edges;

  initial begin
    abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
    empty_blk = {32'h80000000, 480'd0};
    two_b1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b2    = {448'd0, 32'h00000000, 32'h000001c0};

    rst_n = 1'b0;
    input_valid = 1'b0;
    H_in = '0;
    M_in = '0;
    #2;
    checkOutput("reset_valid", {255'b0, output_valid}, 256'd0);
    checkOutput("reset_hash", H_out, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job("abc", IV, abc_blk,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 1'b0);
    run_job("empty", IV, empty_blk,
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 1'b0);
    r1_exp = sha_model(IV, two_b1);
    run_job("two_blk1", IV, two_b1, r1_exp, 1'b0);
    run_job("two_blk2", r1_exp, two_b2,
            256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 1'b0);
    run_job("scramble", IV, abc_blk,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 1'b1);

    // Abort mid-RUN: outputs clear at once and no result ever appears
    applyStimulus(IV, empty_blk);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", {255'b0, output_valid}, 256'd0);
    checkOutput("abort_hash", H_out, 256'd0);
    rise_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    checkOutput("abort_no_pulse", 256'(rise_cnt), 256'd0);

    // Random jobs, each started straight out of a reset pulse with input_valid held
    for (int j = 0; j < 100; j++) begin
      hv = (j % 4 == 0) ? IV : rand256();
      mv = rand512();
      last_exp = sha_model(hv, mv);
      applyStimulus(hv, mv);
      rst_n = 1'b0;
      #1;
      rise_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
      do begin
        @(posedge clk);
        #1;
        edges++;
      end while (!output_valid && edges < 200);
      checkOutput("rand_latency", 256'(edges), 256'd66);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rand_one_pulse", 256'(rise_cnt), 256'd1);
      checkOutput("rand_hash", H_out, last_exp);
    end

    // Still in DONE with input_valid high: result held, no restart
    repeat (70) @(posedge clk);
    #1;
    checkOutput("hold_valid", {255'b0, output_valid}, 256'd1);
    checkOutput("hold_hash", H_out, last_exp);
    checkOutput("hold_one_pulse", 256'(rise_cnt), 256'd1);
    input_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drop_valid", {255'b0, output_valid}, 256'd0);
    checkOutput("drop_hash", H_out, last_exp);
    mv = rand512();
    run_job("restart", IV, mv, sha_model(IV, mv), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- Single-block SHA-256 compression engine (FIPS 180-4).
- Takes a 256-bit chaining value and one pre-padded 512-bit message block, runs 64 rounds at one round per clock, and returns the updated 256-bit hash.
- Sits in the hash datapath. The caller supplies H_in, either the standard initial hash constant (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) or a previous H_out for multi-block messages.
- Padding and message splitting are the caller's job.

Parameters:
none (fixed SHA-256; the 64 K round constants are hard-wired per FIPS 180-4).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
H_in  input  256  chaining value; [255:224]=H0 … [31:0]=H7
M_in  input  512  padded message block, big-endian words; [511:480]=W0 … [31:0]=W15
input_valid  input  1  request to start; sampled only in IDLE
H_out  output  256  result hash, same word ordering as H_in
output_valid  output  1  high while H_out holds a valid result

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low immediately clears all state.
- Reset state: FSM=IDLE, output_valid=0, H_out=0, round counter=0, working regs a..h=0, W window=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - on a rising edge with input_valid=1, latch H_in into the saved-H register and into a..h (a=H0 … h=H7);
  - load the 16-word W window from M_in;
  - clear the round counter t; go to RUN. This is the accept edge, E0.
  - input_valid=0 → stay in IDLE.
- RUN:
  - each edge performs round t (t=0..63): T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = Σ0(a) + Maj(a,b,c);
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - All additions are modulo 2^32; carries are discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Schedule for t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], with σ0 = ROTR7^ROTR18^SHR3 and σ1 = ROTR17^ROTR19^SHR10. It is implemented as a 16-word shift window (rounds 0..15 use the loaded words directly).
  - Rounds occupy edges E1..E64. After round 63, go to DONE.
- Finalize:
  - at edge E65, H_out ← {H0+a, H1+b, …, H7+h} (each mod 2^32) and output_valid ← 1.
  - Total latency: output_valid rises on the 65th rising edge after the accept edge.
- DONE:
  - H_out and output_valid are held stable.
  - When input_valid is sampled low, go to IDLE and clear output_valid; H_out keeps its last value.
  - While input_valid stays high, remain in DONE. A new job needs input_valid low for ≥1 cycle, or a reset.
- input_valid, H_in and M_in are ignored during RUN/DONE, so they may change after E0 without effect.
- rst_n asserted mid-RUN or in DONE aborts the job immediately; everything returns to reset values.
- The first accept after reset release may occur on the first rising edge with rst_n high.
- output_valid is registered, glitch-free, and produces exactly one rising edge per completed block.

Test Plan:
- Reset, then input_valid=1 with H_in=initial constant and M_in="abc" block (61626380, 13 zero words, 00000018) → after 65 edges, output_valid=1 and H_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same with M_in = empty-string block (80000000, 15 zero words) → H_out=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": feed block 1, then block 2 with H_in=first H_out → final H_out=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Change M_in/H_in mid-RUN → result unchanged. Assert rst_n low mid-RUN → output_valid=0, H_out=0 immediately; no later output_valid pulse.
- 100 back-to-back jobs, each preceded by a reset pulse with input_valid held high, random blocks checked against a software model → exactly one output_valid rising edge per job, all hashes match.
- Hold input_valid high in DONE → output_valid stays 1, no restart. Drop input_valid for 1 cycle, then raise it → output_valid clears, a new job starts, and it finishes after 65 edges.
